// File: rtl/btn_evt_pkg.sv
// Shared types and constants for the button event arbiter.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    TrkIdle,
    TrkHeld,
    TrkLongSent
  } trk_state_e;

  localparam int unsigned ID_W_DEF       = 2;
  localparam int unsigned LONG_PRESS_SIM = 8;

endpackage

// File: rtl/btn_press_tracker.sv
// Per-button press tracker: turns a debounced level into one short or long press event.
module btn_press_tracker
  import btn_evt_pkg::*;
#(
  parameter int unsigned CNT_W             = 26,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic lvl,
  input  logic en,
  output logic post,
  output logic post_long,
  output logic active
);

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] PreLast = CNT_W'(LONG_PRESS_CYCLES - 2);

  trk_state_e       r_state;
  logic             r_prev_lvl;
  logic [CNT_W-1:0] r_cnt;
  logic             w_held;
  logic             w_at_thresh;

  assign w_held      = en && (r_state == TrkHeld);
  assign w_at_thresh = (r_cnt == PreLast);

  // Events are posted on the same edge that recognises the release or threshold.
  assign post      = w_held && (!lvl || w_at_thresh);
  assign post_long = w_held && lvl && w_at_thresh;
  assign active    = (r_state == TrkHeld) || (r_state == TrkLongSent);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= TrkIdle;
      r_prev_lvl <= 1'b1;
      r_cnt      <= '0;
    end else begin
      r_prev_lvl <= lvl;
      if (!en) begin
        r_state <= TrkIdle;
      end else begin
        case (r_state)
          TrkIdle: begin
            if (lvl && !r_prev_lvl) begin
              r_state <= TrkHeld;
              r_cnt   <= '0;
            end
          end
          TrkHeld: begin
            if (!lvl) begin
              r_state <= TrkIdle;
            end else if (w_at_thresh) begin
              r_state <= TrkLongSent;
              r_cnt   <= LastCnt;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          TrkLongSent: begin
            if (!lvl) r_state <= TrkIdle;
          end
          default: r_state <= TrkIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/btn_event_arbiter.sv
// Button press events: per-button trackers, one pending slot each, round-robin output channel.
module btn_event_arbiter
  import btn_evt_pkg::*;
#(
  parameter int unsigned NUM_BTN           = 4,
  parameter int unsigned ID_W              = ID_W_DEF,
  parameter int unsigned CNT_W             = 26,
  parameter int unsigned LONG_PRESS_CYCLES = 50_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_lvl,
  input  logic [NUM_BTN-1:0] btn_en,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic               evt_long,
  output logic [NUM_BTN-1:0] hold_active,
  output logic               overflow,
  input  logic               ovf_clr
);

  localparam logic [ID_W-1:0] LastIdx = ID_W'(NUM_BTN - 1);

  logic [NUM_BTN-1:0] w_post;
  logic [NUM_BTN-1:0] w_post_long;
  logic [NUM_BTN-1:0] w_grant;
  logic [NUM_BTN-1:0] w_drop;
  logic [NUM_BTN-1:0] r_pend;
  logic [NUM_BTN-1:0] r_pend_long;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_found;
  logic               w_load;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_trk
    btn_press_tracker #(
      .CNT_W            (CNT_W),
      .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
    ) u_trk (
      .clk      (clk),
      .reset    (reset),
      .lvl      (btn_lvl[g]),
      .en       (btn_en[g]),
      .post     (w_post[g]),
      .post_long(w_post_long[g]),
      .active   (hold_active[g])
    );
  end

  assign w_load = !evt_valid || evt_ready;

  // First pass covers rr_ptr..NUM_BTN-1, second pass supplies the wrap-around part.
  always_comb begin
    w_found   = 1'b0;
    w_gnt_idx = '0;
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      if (!w_found && r_pend[k] && (k >= 32'(r_rr_ptr))) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(k);
      end
    end
    for (int unsigned k = 0; k < NUM_BTN; k++) begin
      if (!w_found && r_pend[k]) begin
        w_found   = 1'b1;
        w_gnt_idx = ID_W'(k);
      end
    end
  end

  assign w_grant = (w_load && w_found) ? (NUM_BTN'(1) << w_gnt_idx) : '0;
  assign w_drop  = w_post & r_pend & ~w_grant;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend      <= '0;
      r_pend_long <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_BTN; k++) begin
        if (w_post[k] && (!r_pend[k] || w_grant[k])) begin
          r_pend[k]      <= 1'b1;
          r_pend_long[k] <= w_post_long[k];
        end else if (w_grant[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
    end else if (|w_drop) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evt_valid <= 1'b0;
      evt_id    <= '0;
      evt_long  <= 1'b0;
      r_rr_ptr  <= '0;
    end else if (w_load) begin
      if (w_found) begin
        evt_valid <= 1'b1;
        evt_id    <= w_gnt_idx;
        evt_long  <= r_pend_long[w_gnt_idx];
        r_rr_ptr  <= (w_gnt_idx == LastIdx) ? '0 : w_gnt_idx + 1'b1;
      end else begin
        evt_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_btn_event_arbiter.sv
// Directed bench for btn_event_arbiter with a short long-press threshold.
module tb_btn_event_arbiter;
  import btn_evt_pkg::*;

  localparam int unsigned NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_lvl;
  logic [NB-1:0] btn_en;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_id;
  logic          evt_long;
  logic [NB-1:0] hold_active;
  logic          overflow;
  logic          ovf_clr;

  int n_err = 0;
  int n_chk = 0;
  logic seen;

  btn_event_arbiter #(
    .NUM_BTN          (NB),
    .ID_W             (2),
    .CNT_W            (4),
    .LONG_PRESS_CYCLES(LONG_PRESS_SIM)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_lvl    (btn_lvl),
    .btn_en     (btn_en),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_id     (evt_id),
    .evt_long   (evt_long),
    .hold_active(hold_active),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    btn_lvl   = '0;
    btn_en    = '1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    btn_lvl   = '0;
    btn_en    = '1;
    evt_ready = 1'b1;
    ovf_clr   = 1'b0;
    #3;
    chk("rst_valid", 32'(evt_valid), 0);
    chk("rst_id", 32'(evt_id), 0);
    chk("rst_long", 32'(evt_long), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_hold", 32'(hold_active), 0);
    tick();
    reset = 1'b1;
    tick();
    tick();

    // 1: short press on btn0
    btn_lvl = 4'b0001;
    tick();
    chk("s1_hold", 32'(hold_active), 32'h1);
    tick();
    tick();
    btn_lvl = 4'b0000;
    tick();
    chk("s1_valid_k", 32'(evt_valid), 0);
    chk("s1_hold_off", 32'(hold_active), 0);
    tick();
    chk("s1_valid", 32'(evt_valid), 1);
    chk("s1_id", 32'(evt_id), 0);
    chk("s1_long", 32'(evt_long), 0);
    tick();
    chk("s1_valid_end", 32'(evt_valid), 0);

    // 2: long press on btn2
    btn_lvl = 4'b0100;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= evt_valid;
    end
    chk("s2_no_early", 32'(seen), 0);
    chk("s2_hold", 32'(hold_active), 32'h4);
    tick();
    chk("s2_valid", 32'(evt_valid), 1);
    chk("s2_id", 32'(evt_id), 2);
    chk("s2_long", 32'(evt_long), 1);
    seen = 1'b0;
    for (int i = 0; i < 11; i++) begin
      tick();
      seen |= evt_valid;
    end
    btn_lvl = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      seen |= evt_valid;
    end
    chk("s2_no_rel_evt", 32'(seen), 0);
    chk("s2_hold_off", 32'(hold_active), 0);

    // 3: simultaneous btn1/btn3 releases, twice
    do_reset();
    for (int r = 0; r < 2; r++) begin
      btn_lvl = 4'b1010;
      tick();
      tick();
      btn_lvl = 4'b0000;
      tick();
      chk("s3_valid_k", 32'(evt_valid), 0);
      tick();
      chk("s3_v1", 32'(evt_valid), 1);
      chk("s3_id1", 32'(evt_id), 1);
      tick();
      chk("s3_v2", 32'(evt_valid), 1);
      chk("s3_id2", 32'(evt_id), 3);
      tick();
      chk("s3_v_end", 32'(evt_valid), 0);
    end

    // 4: backpressure and overflow on btn0
    do_reset();
    evt_ready = 1'b0;
    btn_lvl   = 4'b0001;
    tick();
    btn_lvl = 4'b0000;
    tick();
    chk("s4_valid_k", 32'(evt_valid), 0);
    btn_lvl = 4'b0001;
    tick();
    chk("s4_v1", 32'(evt_valid), 1);
    chk("s4_id1", 32'(evt_id), 0);
    btn_lvl = 4'b0000;
    tick();
    chk("s4_ovf_pre", 32'(overflow), 0);
    btn_lvl = 4'b0001;
    tick();
    btn_lvl = 4'b0000;
    tick();
    chk("s4_ovf_set", 32'(overflow), 1);
    chk("s4_held_v", 32'(evt_valid), 1);
    chk("s4_held_id", 32'(evt_id), 0);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("s4_ovf_clr", 32'(overflow), 0);
    evt_ready = 1'b1;
    tick();
    chk("s4_v2", 32'(evt_valid), 1);
    chk("s4_id2", 32'(evt_id), 0);
    tick();
    chk("s4_third_dropped", 32'(evt_valid), 0);

    // 5: btn1 held across reset release
    reset     = 1'b0;
    btn_lvl   = 4'b0010;
    btn_en    = '1;
    evt_ready = 1'b1;
    tick();
    reset = 1'b1;
    seen  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= evt_valid;
    end
    chk("s5_hold_thru_rst", 32'(hold_active), 0);
    btn_lvl = 4'b0000;
    tick();
    seen |= evt_valid;
    tick();
    seen |= evt_valid;
    chk("s5_no_evt_rst", 32'(seen), 0);
    btn_lvl = 4'b0010;
    tick();
    tick();
    btn_lvl = 4'b0000;
    tick();
    tick();
    chk("s5_valid", 32'(evt_valid), 1);
    chk("s5_id", 32'(evt_id), 1);
    chk("s5_long", 32'(evt_long), 0);
    tick();
    chk("s5_once", 32'(evt_valid), 0);

    // 6: enable dropped mid-hold on btn2
    do_reset();
    btn_lvl = 4'b0100;
    for (int i = 0; i < 5; i++) tick();
    chk("s6_hold", 32'(hold_active), 32'h4);
    btn_en = 4'b1011;
    tick();
    chk("s6_abort", 32'(hold_active), 0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen |= evt_valid;
    end
    btn_en = '1;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= evt_valid;
    end
    btn_lvl = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= evt_valid;
    end
    chk("s6_no_evt", 32'(seen), 0);
    chk("s6_ovf", 32'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
